// File: rtl/sun_pll_lockdet_pkg.sv
// Shared state encoding and default parameters for the PLL lock detector.
package sun_pll_lockdet_pkg;

  localparam int unsigned DIV_RATIO_DEF = 128;
  localparam int unsigned TOL_DEF       = 2;
  localparam int unsigned LOCK_CNT_DEF  = 4;
  localparam int unsigned CNT_W_DEF     = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_MEAS = 2'd2,
    ST_LOCK = 2'd3
  } lockdet_state_e;

endpackage

// File: rtl/sun_pll_sync2.sv
// Two-flop synchronizer for the reference clock plus a rising-edge detector
// producing a one-cycle pulse in the CK domain.
module sun_pll_sync2 (
  input  logic ck_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  // synchronizer chain and delayed copy for edge detection
  always_ff @(posedge ck_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign edge_o = s2_q & ~prev_q;

endmodule

// File: rtl/sun_pll_lockdet.sv
// PLL lock detector: measures CK cycles per CK_REF period and tracks lock.
// Optional sticky loss-of-lock flag is built when SUN_PLL_LOCKDET_LOL_EN is defined.
module sun_pll_lockdet
  import sun_pll_lockdet_pkg::*;
#(
  parameter int unsigned DIV_RATIO = DIV_RATIO_DEF,
  parameter int unsigned TOL       = TOL_DEF,
  parameter int unsigned LOCK_CNT  = LOCK_CNT_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             ck_i,
  input  logic             rst_i,
  input  logic             ck_ref_i,
  input  logic             en_i,
  input  logic             lol_clr_i,
  output logic             locked_o,
  output logic             unlock_evt_o,
  output logic             lol_o,
  output logic [CNT_W-1:0] fcnt_o,
  output logic             fcnt_vld_o
);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   DIV_X      = DIV_RATIO[CNT_W:0];
  localparam logic [CNT_W:0]   TOL_X      = TOL[CNT_W:0];
  localparam logic [3:0]       LOCK_CNT_V = LOCK_CNT[3:0];

  logic             ref_edge_s;
  lockdet_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [3:0]       good_q, good_d, good_inc_s;
  logic             fcnt_vld_q, fcnt_vld_d;
  logic             locked_q, locked_d;
  logic             unlock_evt_q, unlock_evt_d;
  logic [CNT_W:0]   cnt_x_s, dev_s;
  logic             meas_good_s;

  sun_pll_sync2 u_sync (
    .ck_i    (ck_i),
    .rst_i   (rst_i),
    .async_i (ck_ref_i),
    .edge_o  (ref_edge_s)
  );

  // deviation is taken one bit wider so the subtraction can never wrap
  always_comb begin
    cnt_x_s = {1'b0, cnt_q};
    if (cnt_x_s >= DIV_X) begin
      dev_s = cnt_x_s - DIV_X;
    end else begin
      dev_s = DIV_X - cnt_x_s;
    end
    meas_good_s = (dev_s <= TOL_X);
    if (good_q >= LOCK_CNT_V) begin
      good_inc_s = LOCK_CNT_V;
    end else begin
      good_inc_s = good_q + 4'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    good_d       = good_q;
    fcnt_d       = fcnt_q;
    fcnt_vld_d   = 1'b0;
    unlock_evt_d = 1'b0;
    if (!en_i) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
      good_d  = 4'd0;
    end else begin
      if (ref_edge_s) begin
        cnt_d = CNT_ONE;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQ;
          cnt_d   = CNT_ZERO;
          good_d  = 4'd0;
        end
        ST_ACQ: begin
          if (ref_edge_s) begin
            state_d = ST_MEAS;
          end else begin
            cnt_d = CNT_ZERO;
          end
        end
        ST_MEAS, ST_LOCK: begin
          if (ref_edge_s) begin
            fcnt_d     = cnt_q;
            fcnt_vld_d = 1'b1;
            if (meas_good_s) begin
              good_d = good_inc_s;
              if (good_inc_s == LOCK_CNT_V) begin
                state_d = ST_LOCK;
              end else begin
                state_d = state_q;
              end
            end else begin
              good_d       = 4'd0;
              state_d      = ST_MEAS;
              unlock_evt_d = (state_q == ST_LOCK);
            end
          end else if ((state_q == ST_LOCK) && (cnt_q == CNT_MAX)) begin
            // reference went missing: counter ran out while locked
            good_d       = 4'd0;
            state_d      = ST_MEAS;
            unlock_evt_d = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    locked_d = (state_d == ST_LOCK);
  end

  // state, counters and registered outputs
  always_ff @(posedge ck_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      good_q       <= 4'd0;
      fcnt_q       <= CNT_ZERO;
      fcnt_vld_q   <= 1'b0;
      locked_q     <= 1'b0;
      unlock_evt_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      good_q       <= good_d;
      fcnt_q       <= fcnt_d;
      fcnt_vld_q   <= fcnt_vld_d;
      locked_q     <= locked_d;
      unlock_evt_q <= unlock_evt_d;
    end
  end

`ifdef SUN_PLL_LOCKDET_LOL_EN
  logic lol_q, lol_d;

  // set wins over clear when both land in the same cycle
  always_comb begin
    if (unlock_evt_d) begin
      lol_d = 1'b1;
    end else if (lol_clr_i) begin
      lol_d = 1'b0;
    end else begin
      lol_d = lol_q;
    end
  end

  // sticky loss-of-lock flag
  always_ff @(posedge ck_i or posedge rst_i) begin
    if (rst_i) begin
      lol_q <= 1'b0;
    end else begin
      lol_q <= lol_d;
    end
  end

  assign lol_o = lol_q;
`else
  logic lol_clr_unused_s;
  assign lol_clr_unused_s = lol_clr_i;
  assign lol_o            = 1'b0;
`endif

  assign locked_o     = locked_q;
  assign unlock_evt_o = unlock_evt_q;
  assign fcnt_o       = fcnt_q;
  assign fcnt_vld_o   = fcnt_vld_q;

endmodule

// File: tb/tb_sun_pll_lockdet.sv
// Self-checking bench for sun_pll_lockdet: directed and random CK_REF periods
// compared each cycle against a period-arithmetic reference model.
module tb_sun_pll_lockdet;

  localparam int DIV  = 128;
  localparam int TOLV = 2;
  localparam int LCNT = 4;
  localparam int CW   = 10;
  localparam int MAXC = (1 << CW) - 1;

  logic          ck      = 1'b0;
  logic          rst     = 1'b1;
  logic          ck_ref  = 1'b0;
  logic          en      = 1'b0;
  logic          lol_clr = 1'b0;
  logic          locked, unlock_evt, lol, fcnt_vld;
  logic [CW-1:0] fcnt;

  int checks   = 0;
  int failures = 0;

  // reference model state: edge timestamps and lock bookkeeping
  int t = 0;
  int h[4];
  int en_d1, armed, last_edge, good;
  int m_locked, m_fcnt, m_vld, m_evt, m_lol;
  int obs_vld, lock_rise_vld, prev_locked, base;

  always #5 ck = ~ck;

  sun_pll_lockdet #(
    .DIV_RATIO (DIV),
    .TOL       (TOLV),
    .LOCK_CNT  (LCNT),
    .CNT_W     (CW)
  ) dut (
    .ck_i         (ck),
    .rst_i        (rst),
    .ck_ref_i     (ck_ref),
    .en_i         (en),
    .lol_clr_i    (lol_clr),
    .locked_o     (locked),
    .unlock_evt_o (unlock_evt),
    .lol_o        (lol),
    .fcnt_o       (fcnt),
    .fcnt_vld_o   (fcnt_vld)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) h[i] = 0;
    en_d1 = 0; armed = 0; last_edge = 0; good = 0;
    m_locked = 0; m_fcnt = 0; m_vld = 0; m_evt = 0; m_lol = 0;
  endtask

  task automatic model_tick(input int en_now, input int clr_now);
    int per, dev;
    m_vld = 0;
    m_evt = 0;
    // a reference rising edge is seen two CK edges after it is sampled
    if (!en_now) begin
      armed = 0; good = 0; m_locked = 0;
    end else if (!en_d1) begin
      armed = 0; good = 0;
    end else if (h[2] == 1 && h[3] == 0) begin
      if (armed) begin
        per = t - last_edge;
        if (per > MAXC) per = MAXC;
        m_fcnt = per;
        m_vld  = 1;
        dev = (per > DIV) ? per - DIV : DIV - per;
        if (dev <= TOLV) begin
          good = (good < LCNT) ? good + 1 : LCNT;
          if (good == LCNT) m_locked = 1;
        end else begin
          good = 0;
          if (m_locked) begin
            m_locked = 0;
            m_evt    = 1;
          end
        end
      end
      armed     = 1;
      last_edge = t;
    end else if (armed && m_locked && (t - last_edge) >= MAXC) begin
      m_locked = 0;
      m_evt    = 1;
      good     = 0;
    end
    en_d1 = en_now;
`ifdef SUN_PLL_LOCKDET_LOL_EN
    if (m_evt) m_lol = 1;
    else if (clr_now) m_lol = 0;
`else
    m_lol = 0;
`endif
  endtask

  task automatic step();
    int en_now, clr_now;
    h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = int'(ck_ref);
    en_now  = int'(en);
    clr_now = int'(lol_clr);
    @(posedge ck);
    #1;
    t++;
    if (rst) model_reset();
    else model_tick(en_now, clr_now);
    check("locked", locked, m_locked);
    check("unlock_evt", unlock_evt, m_evt);
    check("lol", lol, m_lol);
    check("fcnt_vld", fcnt_vld, m_vld);
    check("fcnt", fcnt, m_fcnt);
    if (fcnt_vld === 1'b1) obs_vld++;
    if (locked === 1'b1 && prev_locked == 0) lock_rise_vld = obs_vld;
    prev_locked = (locked === 1'b1) ? 1 : 0;
  endtask

  task automatic run_period(input int p);
    for (int i = 0; i < p; i++) begin
      ck_ref = (i < p / 2);
      step();
    end
  endtask

  task automatic idle(input int n);
    ck_ref = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    obs_vld = 0; lock_rise_vld = -1; prev_locked = 0;

    // reset, then enable with the reference quiet
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    idle(2);
    en = 1'b1;
    idle(4);

    // nominal lock: first edge arms, lock at the 4th measurement
    base = obs_vld; lock_rise_vld = -1;
    for (int i = 0; i < 5; i++) run_period(128);
    check("lock_at_4th_vld", lock_rise_vld - base, LCNT);
    check("fcnt_nominal", fcnt, 128);
    run_period(128);
    run_period(128);

    // tolerance corners
    run_period(130);
    run_period(126);
    run_period(131);
    for (int i = 0; i < 4; i++) run_period(128);
    run_period(125);
    for (int i = 0; i < 5; i++) run_period(128);

    // loss of lock through a long period, then clear the sticky flag
    run_period(140);
    run_period(128);
    check("fcnt_long", fcnt, 140);
    for (int i = 0; i < 3; i++) run_period(128);
    lol_clr = 1'b1;
    step();
    lol_clr = 1'b0;
    for (int i = 0; i < 2; i++) run_period(128);

    // missing reference while locked
    idle(1100);
    check("timeout_locked", locked, 0);
    check("timeout_fcnt", fcnt, 128);
    for (int i = 0; i < 6; i++) run_period(128);

    // asynchronous reset mid-period while locked
    ck_ref = 1'b1;
    for (int i = 0; i < 64; i++) step();
    idle(30);
    rst = 1'b1;
    #1;
    check("rst_locked", locked, 0);
    check("rst_fcnt", fcnt, 0);
    check("rst_vld", fcnt_vld, 0);
    check("rst_evt", unlock_evt, 0);
    check("rst_lol", lol, 0);
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    idle(20);
    base = obs_vld; lock_rise_vld = -1;
    for (int i = 0; i < 5; i++) run_period(128);
    check("relock_after_rst", lock_rise_vld - base, LCNT);
    run_period(128);

    // enable drops on the very cycle the edge is processed
    ck_ref = 1'b1;
    step();
    step();
    en = 1'b0;
    base = obs_vld;
    step();
    check("en_drop_vld", fcnt_vld, 0);
    check("en_drop_locked", locked, 0);
    for (int i = 0; i < 61; i++) step();
    idle(64);
    check("en_drop_no_meas", obs_vld - base, 0);
    en = 1'b1;
    idle(10);

    // randomized periods around the nominal ratio
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) == 0) run_period(140);
      else run_period(int'($urandom_range(122, 134)));
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
